// File: rtl/reg_bank_pkg.sv
// Shared types and constants for the register-bank sequencer.
package reg_bank_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        DRIVE   = 2'd1,
        STROBE  = 2'd2,
        RELEASE = 2'd3
    } state_t;

    localparam int NREG_DEF = 4;

    // Width of the DRIVE settle down-counter; supports SETTLE up to 16.
    localparam int CNT_W = 4;

endpackage

// File: rtl/reg_bank_ctrl_onehot_dec.sv
// Select-to-one-hot decoder with an in-range flag.
// An out-of-range select yields an all-zero vector and ok=0.
module onehot_dec #(
    parameter int NREG  = 4,
    parameter int SEL_W = 2
) (
    input  logic [SEL_W-1:0] sel,
    output logic [NREG-1:0]  hot,
    output logic             ok
);

    // Compare the select against every register index.
    always_comb begin
        hot = '0;
        for (int i = 0; i < NREG; i++) begin
            hot[i] = (sel == SEL_W'(i));
        end
        ok = |hot;
    end

endmodule

// File: rtl/reg_bank_ctrl.sv
// Sequencer for a bank of NREG bus registers: drives active-low bus A/B enables,
// a single write strobe, and enforces break-before-make between ops.
// Optional build macro REG_BANK_CTRL_WRCNT_EN adds a 16-bit write-strobe counter (wr_count).
module reg_bank_ctrl
    import reg_bank_pkg::*;
#(
    parameter int NREG   = NREG_DEF,
    parameter int SEL_W  = $clog2(NREG),
    parameter int SETTLE = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             op_valid,
    output logic             op_ready,
    input  logic [SEL_W-1:0] sel_a,
    input  logic [SEL_W-1:0] sel_b,
    input  logic [SEL_W-1:0] sel_w,
    input  logic             we,
    output logic [NREG-1:0]  n_oe_a,
    output logic [NREG-1:0]  n_oe_b,
    output logic [NREG-1:0]  w_clk,
`ifdef REG_BANK_CTRL_WRCNT_EN
    output logic [15:0]      wr_count,
`endif
    output logic             done,
    output logic             sel_err
);

    state_t             state, state_nxt;
    logic [CNT_W-1:0]   cnt, cnt_nxt;

    // Decoded selects captured at accept; held for the whole op.
    logic [NREG-1:0]    hot_a, hot_b, hot_w;
    logic [NREG-1:0]    hot_a_nxt, hot_b_nxt, hot_w_nxt;
    logic               we_q, we_nxt;

    logic [NREG-1:0]    dec_a, dec_b, dec_w;
    logic               ok_a, ok_b, ok_w;

    logic [NREG-1:0]    n_oe_a_nxt, n_oe_b_nxt, w_clk_nxt;
    logic               done_nxt, sel_err_nxt, op_ready_nxt;
    logic               accept;

    onehot_dec #(.NREG(NREG), .SEL_W(SEL_W)) u_dec_a (.sel(sel_a), .hot(dec_a), .ok(ok_a));
    onehot_dec #(.NREG(NREG), .SEL_W(SEL_W)) u_dec_b (.sel(sel_b), .hot(dec_b), .ok(ok_b));
    onehot_dec #(.NREG(NREG), .SEL_W(SEL_W)) u_dec_w (.sel(sel_w), .hot(dec_w), .ok(ok_w));

    assign accept = op_valid && op_ready;

    // Next state and next registered outputs; every output is computed one cycle
    // ahead so that the ports are driven straight from flops.
    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        hot_a_nxt   = hot_a;
        hot_b_nxt   = hot_b;
        hot_w_nxt   = hot_w;
        we_nxt      = we_q;
        n_oe_a_nxt  = '1;
        n_oe_b_nxt  = '1;
        w_clk_nxt   = '0;
        done_nxt    = 1'b0;
        sel_err_nxt = 1'b0;
        unique case (state)
            IDLE: begin
                if (accept) begin
                    hot_a_nxt   = dec_a;
                    hot_b_nxt   = dec_b;
                    hot_w_nxt   = dec_w;
                    we_nxt      = we;
                    cnt_nxt     = CNT_W'(SETTLE - 1);
                    n_oe_a_nxt  = ~dec_a;
                    n_oe_b_nxt  = ~dec_b;
                    sel_err_nxt = !(ok_a && ok_b && ok_w);
                    state_nxt   = DRIVE;
                end
            end
            DRIVE: begin
                n_oe_a_nxt = ~hot_a;
                n_oe_b_nxt = ~hot_b;
                if (cnt == '0) begin
                    w_clk_nxt = we_q ? hot_w : '0;
                    state_nxt = STROBE;
                end else begin
                    cnt_nxt = cnt - CNT_W'(1);
                end
            end
            STROBE: begin
                // Enables stay on through RELEASE to give hold time after the strobe falls.
                n_oe_a_nxt = ~hot_a;
                n_oe_b_nxt = ~hot_b;
                done_nxt   = 1'b1;
                state_nxt  = RELEASE;
            end
            RELEASE: begin
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
        op_ready_nxt = (state_nxt == IDLE);
    end

    // Control and output registers; reset drops any op in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= '0;
            n_oe_a   <= '1;
            n_oe_b   <= '1;
            w_clk    <= '0;
            done     <= 1'b0;
            sel_err  <= 1'b0;
            op_ready <= 1'b0;
        end else begin
            state    <= state_nxt;
            cnt      <= cnt_nxt;
            n_oe_a   <= n_oe_a_nxt;
            n_oe_b   <= n_oe_b_nxt;
            w_clk    <= w_clk_nxt;
            done     <= done_nxt;
            sel_err  <= sel_err_nxt;
            op_ready <= op_ready_nxt;
        end
    end

    // Captured op fields; only meaningful while an op is in flight.
    always_ff @(posedge clk) begin
        hot_a <= hot_a_nxt;
        hot_b <= hot_b_nxt;
        hot_w <= hot_w_nxt;
        we_q  <= we_nxt;
    end

`ifdef REG_BANK_CTRL_WRCNT_EN
    // Count issued write strobes, wrapping at 16 bits.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_count <= '0;
        end else if (|w_clk_nxt) begin
            wr_count <= wr_count + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_reg_bank_ctrl.sv
// Directed bench for reg_bank_ctrl: a NREG=4 instance for the main sequences and
// a NREG=6 instance for the out-of-range select case.
// Build macro REG_BANK_CTRL_WRCNT_EN additionally checks wr_count.
module tb_reg_bank_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b1;

    // NREG=4 instance
    logic       op_valid = 1'b0;
    logic       op_ready;
    logic [1:0] sel_a = '0, sel_b = '0, sel_w = '0;
    logic       we = 1'b0;
    logic [3:0] n_oe_a, n_oe_b, w_clk;
    logic       done, sel_err;

    // NREG=6 instance
    logic       op_valid6 = 1'b0;
    logic       op_ready6;
    logic [2:0] sel_a6 = '0, sel_b6 = '0, sel_w6 = '0;
    logic       we6 = 1'b0;
    logic [5:0] n_oe_a6, n_oe_b6, w_clk6;
    logic       done6, sel_err6;

`ifdef REG_BANK_CTRL_WRCNT_EN
    logic [15:0] wr_count, wr_count6;
`endif

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    reg_bank_ctrl #(.NREG(4), .SEL_W(2), .SETTLE(1)) dut (
        .clk(clk), .rst(rst), .op_valid(op_valid), .op_ready(op_ready),
        .sel_a(sel_a), .sel_b(sel_b), .sel_w(sel_w), .we(we),
        .n_oe_a(n_oe_a), .n_oe_b(n_oe_b), .w_clk(w_clk),
`ifdef REG_BANK_CTRL_WRCNT_EN
        .wr_count(wr_count),
`endif
        .done(done), .sel_err(sel_err)
    );

    reg_bank_ctrl #(.NREG(6), .SEL_W(3), .SETTLE(1)) dut6 (
        .clk(clk), .rst(rst), .op_valid(op_valid6), .op_ready(op_ready6),
        .sel_a(sel_a6), .sel_b(sel_b6), .sel_w(sel_w6), .we(we6),
        .n_oe_a(n_oe_a6), .n_oe_b(n_oe_b6), .w_clk(w_clk6),
`ifdef REG_BANK_CTRL_WRCNT_EN
        .wr_count(wr_count6),
`endif
        .done(done6), .sel_err(sel_err6)
    );

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        // Reset held two cycles
        rst = 1'b1;
        tick();
        tick();
        check_val("rst_oe_a", 32'(n_oe_a), 32'hF);
        check_val("rst_oe_b", 32'(n_oe_b), 32'hF);
        check_val("rst_wclk", 32'(w_clk), 32'h0);
        check_val("rst_ready", 32'(op_ready), 32'h0);
        check_val("rst_done", 32'(done), 32'h0);
        rst = 1'b0;
        tick();
        check_val("ready_after_rst", 32'(op_ready), 32'h1);

        // Op 1: A=1, B=2, W=3, write
        op_valid = 1'b1; sel_a = 2'd1; sel_b = 2'd2; sel_w = 2'd3; we = 1'b1;
        tick();
        op_valid = 1'b0; sel_a = 2'd0; sel_b = 2'd0; sel_w = 2'd0; we = 1'b0;
        check_val("op1_drive_oe_a", 32'(n_oe_a), 32'hD);
        check_val("op1_drive_oe_b", 32'(n_oe_b), 32'hB);
        check_val("op1_drive_wclk", 32'(w_clk), 32'h0);
        check_val("op1_drive_ready", 32'(op_ready), 32'h0);
        check_val("op1_sel_err", 32'(sel_err), 32'h0);
        tick();
        check_val("op1_strobe_oe_a", 32'(n_oe_a), 32'hD);
        check_val("op1_strobe_oe_b", 32'(n_oe_b), 32'hB);
        check_val("op1_strobe_wclk", 32'(w_clk), 32'h8);
        check_val("op1_strobe_done", 32'(done), 32'h0);
        tick();
        check_val("op1_rel_oe_a", 32'(n_oe_a), 32'hD);
        check_val("op1_rel_oe_b", 32'(n_oe_b), 32'hB);
        check_val("op1_rel_wclk", 32'(w_clk), 32'h0);
        check_val("op1_rel_done", 32'(done), 32'h1);
        tick();
        check_val("op1_idle_oe_a", 32'(n_oe_a), 32'hF);
        check_val("op1_idle_oe_b", 32'(n_oe_b), 32'hF);
        check_val("op1_idle_done", 32'(done), 32'h0);
        check_val("op1_idle_ready", 32'(op_ready), 32'h1);
`ifdef REG_BANK_CTRL_WRCNT_EN
        check_val("op1_wrcnt", 32'(wr_count), 32'd1);
`endif

        // Op 2: read-only, A=B=0
        op_valid = 1'b1; sel_a = 2'd0; sel_b = 2'd0; sel_w = 2'd2; we = 1'b0;
        tick();
        op_valid = 1'b0;
        check_val("op2_drive_oe_a", 32'(n_oe_a), 32'hE);
        check_val("op2_drive_oe_b", 32'(n_oe_b), 32'hE);
        check_val("op2_drive_wclk", 32'(w_clk), 32'h0);
        tick();
        check_val("op2_strobe_oe_a", 32'(n_oe_a), 32'hE);
        check_val("op2_strobe_wclk", 32'(w_clk), 32'h0);
        tick();
        check_val("op2_rel_wclk", 32'(w_clk), 32'h0);
        check_val("op2_rel_done", 32'(done), 32'h1);
        tick();
        check_val("op2_idle_oe_b", 32'(n_oe_b), 32'hF);
`ifdef REG_BANK_CTRL_WRCNT_EN
        check_val("op2_wrcnt", 32'(wr_count), 32'd1);
`endif

        // Back-to-back ops with op_valid held: A=2, B=3, W=1
        op_valid = 1'b1; sel_a = 2'd2; sel_b = 2'd3; sel_w = 2'd1; we = 1'b1;
        tick();
        check_val("b2b1_drive_oe_a", 32'(n_oe_a), 32'hB);
        check_val("b2b1_drive_oe_b", 32'(n_oe_b), 32'h7);
        tick();
        check_val("b2b1_strobe_wclk", 32'(w_clk), 32'h2);
        tick();
        check_val("b2b1_rel_done", 32'(done), 32'h1);
        tick();
        check_val("b2b_gap_oe_a", 32'(n_oe_a), 32'hF);
        check_val("b2b_gap_oe_b", 32'(n_oe_b), 32'hF);
        check_val("b2b_gap_ready", 32'(op_ready), 32'h1);
        tick();
        op_valid = 1'b0;
        check_val("b2b2_drive_oe_a", 32'(n_oe_a), 32'hB);
        check_val("b2b2_drive_ready", 32'(op_ready), 32'h0);
        tick();
        check_val("b2b2_strobe_wclk", 32'(w_clk), 32'h2);
        tick();
        check_val("b2b2_rel_done", 32'(done), 32'h1);
        tick();
`ifdef REG_BANK_CTRL_WRCNT_EN
        check_val("b2b_wrcnt", 32'(wr_count), 32'd3);
`endif

        // Reset during STROBE: A=B=W=0, write
        op_valid = 1'b1; sel_a = 2'd0; sel_b = 2'd0; sel_w = 2'd0; we = 1'b1;
        tick();
        op_valid = 1'b0;
        tick();
        check_val("rstmid_strobe_wclk", 32'(w_clk), 32'h1);
        rst = 1'b1;
        tick();
        check_val("rstmid_oe_a", 32'(n_oe_a), 32'hF);
        check_val("rstmid_oe_b", 32'(n_oe_b), 32'hF);
        check_val("rstmid_wclk", 32'(w_clk), 32'h0);
        check_val("rstmid_done", 32'(done), 32'h0);
        check_val("rstmid_ready", 32'(op_ready), 32'h0);
`ifdef REG_BANK_CTRL_WRCNT_EN
        check_val("rstmid_wrcnt", 32'(wr_count), 32'd0);
`endif
        rst = 1'b0;
        tick();
        check_val("rstmid_after_done", 32'(done), 32'h0);
        check_val("rstmid_after_ready", 32'(op_ready), 32'h1);
        tick();
        check_val("rstmid_after2_done", 32'(done), 32'h0);
        check_val("rstmid_after2_wclk", 32'(w_clk), 32'h0);

        // NREG=6: A=0, B=5, W=7 (out of range)
        op_valid6 = 1'b1; sel_a6 = 3'd0; sel_b6 = 3'd5; sel_w6 = 3'd7; we6 = 1'b1;
        tick();
        op_valid6 = 1'b0;
        check_val("n6_sel_err", 32'(sel_err6), 32'h1);
        check_val("n6_drive_oe_a", 32'(n_oe_a6), 32'h3E);
        check_val("n6_drive_oe_b", 32'(n_oe_b6), 32'h1F);
        tick();
        check_val("n6_sel_err_clear", 32'(sel_err6), 32'h0);
        check_val("n6_strobe_wclk", 32'(w_clk6), 32'h0);
        tick();
        check_val("n6_rel_wclk", 32'(w_clk6), 32'h0);
        check_val("n6_rel_done", 32'(done6), 32'h1);
        tick();
        check_val("n6_idle_ready", 32'(op_ready6), 32'h1);
`ifdef REG_BANK_CTRL_WRCNT_EN
        check_val("n6_wrcnt", 32'(wr_count6), 32'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
